// File: rtl/sdram0_read_arbiter_if.sv
// rtl/sdram0_read_arbiter_if.sv - requester and f2h_sdram0 read-port signals around the arbiter
// slave: arbiter view; master: environment view (requesters plus SDRAM port model).
interface sdram0_read_arbiter_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 8
);
  logic [ADDR_W-1:0]  r0_address;
  logic [BURST_W-1:0] r0_burstcount;
  logic               r0_read;
  logic               r0_waitrequest;
  logic [DATA_W-1:0]  r0_readdata;
  logic               r0_readdatavalid;

  logic [ADDR_W-1:0]  r1_address;
  logic [BURST_W-1:0] r1_burstcount;
  logic               r1_read;
  logic               r1_waitrequest;
  logic [DATA_W-1:0]  r1_readdata;
  logic               r1_readdatavalid;

  logic [ADDR_W-1:0]  avm_address;
  logic [BURST_W-1:0] avm_burstcount;
  logic               avm_read;
  logic               avm_waitrequest;
  logic [DATA_W-1:0]  avm_readdata;
  logic               avm_readdatavalid;

  modport slave (
    input  r0_address, r0_burstcount, r0_read,
    output r0_waitrequest, r0_readdata, r0_readdatavalid,
    input  r1_address, r1_burstcount, r1_read,
    output r1_waitrequest, r1_readdata, r1_readdatavalid,
    output avm_address, avm_burstcount, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport master (
    output r0_address, r0_burstcount, r0_read,
    input  r0_waitrequest, r0_readdata, r0_readdatavalid,
    output r1_address, r1_burstcount, r1_read,
    input  r1_waitrequest, r1_readdata, r1_readdatavalid,
    input  avm_address, avm_burstcount, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sdram0_read_arbiter.sv
// rtl/sdram0_read_arbiter.sv - round-robin two-requester arbiter for the f2h_sdram0 read burst port
// Optional DATA-phase watchdog with sticky timeout_err: define SDRAM0_ARB_TIMEOUT_EN.
module sdram0_read_arbiter #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int BURST_W        = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  sdram0_read_arbiter_if.slave bus,
  output logic                 busy
`ifdef SDRAM0_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]  avm_address_q, avm_address_d;
  logic [BURST_W-1:0] avm_burstcount_q, avm_burstcount_d;
  logic [BURST_W-1:0] beats_left_q, beats_left_d;
  logic               avm_read_q, avm_read_d;
  logic               busy_q, busy_d;
  logic               r0_valid_q, r0_valid_d, r1_valid_q, r1_valid_d;
  logic [DATA_W-1:0]  r0_data_q, r0_data_d, r1_data_q, r1_data_d;
  logic               pick;
  logic [BURST_W-1:0] req_bc;
  logic               accept;

`ifdef SDRAM0_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  assign accept = (state_q == S_CMD) && !bus.avm_waitrequest;
  assign pick   = (bus.r0_read && bus.r1_read) ? ~last_grant_q : bus.r1_read;
  assign req_bc = pick ? bus.r1_burstcount : bus.r0_burstcount;

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    avm_address_d    = avm_address_q;
    avm_burstcount_d = avm_burstcount_q;
    beats_left_d     = beats_left_q;
    avm_read_d       = avm_read_q;
    r0_valid_d       = 1'b0;
    r1_valid_d       = 1'b0;
    r0_data_d        = r0_data_q;
    r1_data_d        = r1_data_q;
`ifdef SDRAM0_ARB_TIMEOUT_EN
    wd_cnt_d         = wd_cnt_q;
    timeout_err_d    = timeout_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.r0_read || bus.r1_read) begin
          grant_d          = pick;
          last_grant_d     = pick;
          avm_address_d    = pick ? bus.r1_address : bus.r0_address;
          avm_burstcount_d = (req_bc == '0) ? BURST_W'(1) : req_bc;
          beats_left_d     = (req_bc == '0) ? BURST_W'(1) : req_bc;
          avm_read_d       = 1'b1;
          state_d          = S_CMD;
        end
      end
      S_CMD: begin
        if (accept) begin
          avm_read_d = 1'b0;
          state_d    = S_DATA;
`ifdef SDRAM0_ARB_TIMEOUT_EN
          wd_cnt_d   = '0;
`endif
        end
      end
      S_DATA: begin
        if (bus.avm_readdatavalid) begin
          if (grant_q) begin
            r1_valid_d = 1'b1;
            r1_data_d  = bus.avm_readdata;
          end else begin
            r0_valid_d = 1'b1;
            r0_data_d  = bus.avm_readdata;
          end
          beats_left_d = beats_left_q - BURST_W'(1);
          if (beats_left_q == BURST_W'(1)) state_d = S_IDLE;
`ifdef SDRAM0_ARB_TIMEOUT_EN
          wd_cnt_d = '0;
        end else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the burst; its late beats then land in IDLE and are dropped.
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q          <= S_IDLE;
      grant_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      beats_left_q     <= '0;
      avm_read_q       <= 1'b0;
      busy_q           <= 1'b0;
      r0_valid_q       <= 1'b0;
      r1_valid_q       <= 1'b0;
      r0_data_q        <= '0;
      r1_data_q        <= '0;
`ifdef SDRAM0_ARB_TIMEOUT_EN
      wd_cnt_q         <= '0;
      timeout_err_q    <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      last_grant_q     <= last_grant_d;
      avm_address_q    <= avm_address_d;
      avm_burstcount_q <= avm_burstcount_d;
      beats_left_q     <= beats_left_d;
      avm_read_q       <= avm_read_d;
      busy_q           <= busy_d;
      r0_valid_q       <= r0_valid_d;
      r1_valid_q       <= r1_valid_d;
      r0_data_q        <= r0_data_d;
      r1_data_q        <= r1_data_d;
`ifdef SDRAM0_ARB_TIMEOUT_EN
      wd_cnt_q         <= wd_cnt_d;
      timeout_err_q    <= timeout_err_d;
`endif
    end
  end

  assign bus.avm_address      = avm_address_q;
  assign bus.avm_burstcount   = avm_burstcount_q;
  assign bus.avm_read         = avm_read_q;
  assign bus.r0_waitrequest   = !(accept && !grant_q);
  assign bus.r1_waitrequest   = !(accept && grant_q);
  assign bus.r0_readdata      = r0_data_q;
  assign bus.r1_readdata      = r1_data_q;
  assign bus.r0_readdatavalid = r0_valid_q;
  assign bus.r1_readdatavalid = r1_valid_q;
  assign busy                 = busy_q;
`ifdef SDRAM0_ARB_TIMEOUT_EN
  assign timeout_err          = timeout_err_q;
`endif

endmodule
